// File: rtl/cpu_pkg.sv
// Shared control-path definitions: sequencer state codes, RV32 base opcodes,
// writeback mux selects and the opcode class latched during decode.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMEM = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // CLS_OTHER doubles as the cleared value and the "unlisted opcode" class.
  typedef enum logic [3:0] {
    CLS_OTHER  = 4'd0,
    CLS_R      = 4'd1,
    CLS_I      = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_SYSTEM = 4'd10
  } op_class_t;

  function automatic logic is_jump(input op_class_t c);
    return (c == CLS_JAL) || (c == CLS_JALR);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_opcode_classify.sv
// Purely combinational map from the 7-bit major opcode to its control class.
module opcode_classify
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   op_class = CLS_JALR;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      OP_SYSTEM: op_class = CLS_SYSTEM;
      default:   op_class = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB walk with a bounded
// data-memory wait, a retired-instruction counter and sticky halt status.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  wb_sel,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  // The counter only needs to reach MEM_TIMEOUT-1; the last waiting cycle halts.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  op_class_t     decoded_class;
  op_class_t     op_class;
  logic [2:0]    next_state;
  logic [CW-1:0] wait_cnt;
  logic          wait_expired;

  opcode_classify u_classify (
    .opcode   (opcode),
    .op_class (decoded_class)
  );

  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: begin
        if ((decoded_class == CLS_SYSTEM) || (decoded_class == CLS_OTHER))
          next_state = ST_HALT;
        else
          next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if ((op_class == CLS_LOAD) || (op_class == CLS_STORE))
          next_state = ST_MEM;
        else if (op_class == CLS_BRANCH)
          next_state = ST_FETCH;
        else
          next_state = ST_WB;
      end
      // A ready arriving on the final allowed cycle still completes the access.
      ST_MEM: begin
        if (dmem_ready)
          next_state = (op_class == CLS_STORE) ? ST_FETCH : ST_WB;
        else if (wait_expired)
          next_state = ST_HALT;
      end
      ST_WB:   next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_class <= CLS_OTHER;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) begin
        op_class <= decoded_class;
        illegal  <= (decoded_class == CLS_OTHER);
      end
      if ((state == ST_MEM) && !dmem_ready && !wait_expired)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if ((state == ST_MEM) && !dmem_ready && wait_expired)
        fault <= 1'b1;
      if (pc_we)
        retired <= retired + 32'd1;
    end
  end

  // Reset masks the PC/register commits so an aborted instruction leaves no trace.
  always_comb begin
    ir_we    = (state == ST_FETCH);
    halted   = (state == ST_HALT);
    busy     = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC) ||
               (state == ST_MEM) || (state == ST_WB);
    dmem_req = (state == ST_MEM);
    dmem_we  = (state == ST_MEM) && (op_class == CLS_STORE);
    reg_we   = (state == ST_WB) && !reset;
    wb_sel   = WB_ALU;
    pc_sel   = 1'b0;
    pc_we    = 1'b0;
    case (state)
      ST_EXEC: begin
        if (op_class == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
        end
      end
      ST_MEM: pc_we = dmem_ready && (op_class == CLS_STORE);
      ST_WB: begin
        pc_we  = 1'b1;
        pc_sel = is_jump(op_class);
        if (op_class == CLS_LOAD)
          wb_sel = WB_DMEM;
        else if (is_jump(op_class))
          wb_sel = WB_PC4;
      end
      default: ;
    endcase
    pc_we = pc_we && !reset;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed vector table, multi-cycle corner
// sequences, and randomized instructions scored against a latency/effect model.
module tb_multicycle_sequencer;
  import cpu_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset, start, branch_taken, dmem_ready;
  logic [6:0]  opcode;
  logic        ir_we, pc_we, pc_sel, reg_we, dmem_req, dmem_we;
  logic        busy, halted, illegal, fault;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic [31:0] retired;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_retired = '0;

  typedef struct {
    logic [6:0] opcode;
    int bt, delay;
    int lat, ir, pc_we, reg_we, req, we, pc_sel, wb_sel, halt, ill, flt;
  } vec_t;

  typedef struct {
    int done, lat, ir, pc_we, reg_we, req, we, pc_sel, wb_sel, halt, ill, flt, quiet;
  } obs_t;

  vec_t       tbl[$];
  vec_t       e;
  obs_t       o;
  logic [2:0] trace_exp [5];
  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
  logic [6:0] rop;
  int         pick, rd;

  multicycle_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .wb_sel(wb_sel),
    .busy(busy), .halted(halted), .illegal(illegal), .fault(fault),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic [6:0] op, int bt, int d, int lat, int pcw, int rw, int rq,
                              int we, int ps, int ws, int h, int il, int fl);
    vec_t v;
    v.opcode = op; v.bt = bt; v.delay = d; v.lat = lat; v.ir = 1; v.pc_we = pcw;
    v.reg_we = rw; v.req = rq; v.we = we; v.pc_sel = ps; v.wb_sel = ws;
    v.halt = h; v.ill = il; v.flt = fl;
    return v;
  endfunction

  // Reference model: per-instruction effects straight from the latency table.
  function automatic vec_t model(logic [6:0] op, int bt, int d);
    vec_t v;
    int   is_load;
    v = mk(op, bt, d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
        v.lat = 4; v.pc_we = 1; v.reg_we = 1;
      end
      7'b1101111, 7'b1100111: begin
        v.lat = 4; v.pc_we = 1; v.reg_we = 1; v.pc_sel = 1; v.wb_sel = 2;
      end
      7'b1100011: begin
        v.lat = 3; v.pc_we = 1; v.pc_sel = bt;
      end
      7'b0100011, 7'b0000011: begin
        is_load = (op == 7'b0000011) ? 1 : 0;
        if (d < TIMEOUT) begin
          v.req = d + 1; v.lat = 4 + d + is_load; v.pc_we = 1;
          v.reg_we = is_load; v.wb_sel = is_load;
        end else begin
          v.req = TIMEOUT; v.lat = 3 + TIMEOUT; v.halt = 1; v.flt = 1;
        end
        v.we = is_load ? 0 : v.req;
      end
      7'b1110011: begin
        v.lat = 2; v.halt = 1;
      end
      default: begin
        v.lat = 2; v.halt = 1; v.ill = 1;
      end
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_retired = '0;
  endtask

  // Called on a negedge in IDLE; returns on the negedge of the FETCH cycle.
  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH; opcode is scrambled once it has been decoded,
  // and start/dmem_ready are randomized wherever they must be ignored.
  task automatic applyStimulus(input vec_t v, output obs_t r);
    r = '{default: 0};
    opcode = v.opcode;
    branch_taken = v.bt[0];
    for (int c = 0; c < 64 && r.done == 0; c++) begin
      if (r.lat >= 2) opcode = 7'($urandom);
      dmem_ready = dmem_req ? (r.req == v.delay) : 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      #1;
      if (halted) begin
        r.done = 1; r.halt = 1; r.ill = int'(illegal); r.flt = int'(fault);
        r.quiet = int'(!(ir_we || pc_we || reg_we || dmem_req || dmem_we || busy));
      end else begin
        r.lat++;
        if (ir_we) r.ir++;
        if (pc_we) begin r.pc_we++; r.pc_sel = int'(pc_sel); end
        if (reg_we) begin r.reg_we++; r.wb_sel = int'(wb_sel); end
        if (dmem_req) r.req++;
        if (dmem_we) r.we++;
        if (pc_we) r.done = 1;
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic compareObs(input string tag, input vec_t x, input obs_t r);
    checkOutput({tag, " finished"}, r.done, 1);
    checkOutput({tag, " cycles"}, r.lat, x.lat);
    checkOutput({tag, " ir_we"}, r.ir, x.ir);
    checkOutput({tag, " pc_we"}, r.pc_we, x.pc_we);
    checkOutput({tag, " reg_we"}, r.reg_we, x.reg_we);
    checkOutput({tag, " dmem_req"}, r.req, x.req);
    checkOutput({tag, " dmem_we"}, r.we, x.we);
    checkOutput({tag, " halted"}, r.halt, x.halt);
    checkOutput({tag, " illegal"}, r.ill, x.ill);
    checkOutput({tag, " fault"}, r.flt, x.flt);
    if (x.pc_we > 0) checkOutput({tag, " pc_sel"}, r.pc_sel, x.pc_sel);
    if (x.reg_we > 0) checkOutput({tag, " wb_sel"}, r.wb_sel, x.wb_sel);
    if (x.halt > 0) checkOutput({tag, " halt quiet"}, r.quiet, 1);
    exp_retired = exp_retired + 32'(x.pc_we);
    checkOutput({tag, " retired"}, retired, exp_retired);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; branch_taken = 1'b0; dmem_ready = 1'b0;

    //            op          bt d   lat pcw rw rq  we ps ws h il fl
    tbl.push_back(mk(7'b0110011, 0, 0,  4, 1, 1, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0010011, 0, 0,  4, 1, 1, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0110111, 0, 0,  4, 1, 1, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0010111, 0, 0,  4, 1, 1, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b1101111, 0, 0,  4, 1, 1, 0,  0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(7'b1100111, 0, 0,  4, 1, 1, 0,  0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(7'b1100011, 1, 0,  3, 1, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(7'b1100011, 0, 0,  3, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0100011, 0, 0,  4, 1, 0, 1,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0100011, 0, 3,  7, 1, 0, 4,  4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0000011, 0, 2,  7, 1, 1, 3,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(7'b0000011, 0, 14, 19, 1, 1, 15, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(7'b0100011, 0, 14, 18, 1, 0, 15, 15, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'b0100011, 0, 15, 18, 0, 0, 15, 15, 0, 0, 1, 0, 1));
    tbl.push_back(mk(7'b0000011, 0, 30, 18, 0, 0, 15, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(7'b1110011, 0, 0,  2, 0, 0, 0,  0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7'b1111111, 0, 0,  2, 0, 0, 0,  0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(7'b0000000, 0, 0,  2, 0, 0, 0,  0, 0, 0, 1, 1, 0));

    resetDut();
    #1;
    checkOutput("reset state", 32'(state), 32'(ST_IDLE));
    checkOutput("reset retired", retired, 32'd0);
    checkOutput("reset status", 32'({busy, halted, illegal, fault}), 32'd0);
    checkOutput("reset enables", 32'({ir_we, pc_we, pc_sel, reg_we, dmem_req, dmem_we, wb_sel}), 32'd0);

    // Reset must win over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset beats start", 32'(state), 32'(ST_IDLE));
    reset = 1'b0; start = 1'b0;

    // R-type walk through the states one cycle at a time.
    trace_exp = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH};
    @(negedge clk);
    opcode = 7'b0110011;
    launch();
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("trace%0d state", i), 32'(state), 32'(trace_exp[i]));
      if (i == 3) begin
        checkOutput("trace WB reg_we", 32'(reg_we), 32'd1);
        checkOutput("trace WB wb_sel", 32'(wb_sel), 32'd0);
      end
      @(negedge clk);
    end
    checkOutput("trace retired", retired, 32'd1);

    resetDut();
    launch();
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], o);
      compareObs($sformatf("vec%0d op=%b", i, tbl[i].opcode), tbl[i], o);
      if (o.halt != 0 || o.done == 0) begin resetDut(); launch(); end
    end

    // Start pulses in HALT are ignored; reset clears the sticky illegal flag.
    resetDut();
    launch();
    applyStimulus(tbl[16], o);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("halt hold%0d", i), 32'({state, halted, busy}), 32'({ST_HALT, 1'b1, 1'b0}));
    end
    start = 1'b0;
    resetDut();
    #1;
    checkOutput("illegal cleared", 32'({illegal, fault, halted}), 32'd0);

    // Reset while a store is completing in MEM: no PC commit, back to IDLE.
    resetDut();
    launch();
    applyStimulus(tbl[0], o);
    compareObs("pre-abort R", tbl[0], o);
    opcode = 7'b0100011;
    dmem_ready = 1'b0;
    for (int c = 0; c < 10 && !dmem_req; c++) @(negedge clk);
    checkOutput("abort reached MEM", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("abort pc_we", 32'({pc_we, reg_we}), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("abort state", 32'(state), 32'(ST_IDLE));
    checkOutput("abort retired", retired, 32'd0);
    checkOutput("abort busy", 32'({busy, dmem_req, dmem_we}), 32'd0);
    reset = 1'b0; dmem_ready = 1'b0;
    exp_retired = '0;

    // Retired counter wraps from all-ones to zero.
    resetDut();
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    exp_retired = 32'hFFFF_FFFF;
    @(negedge clk);
    launch();
    applyStimulus(tbl[0], o);
    compareObs("wrap R", tbl[0], o);
    checkOutput("wrap to zero", retired, 32'd0);

    // Randomized instruction stream against the model.
    resetDut();
    launch();
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 11);
      rop = (pick < 10) ? legal_ops[pick] : 7'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 5);
      e = model(rop, $urandom_range(0, 1), rd);
      applyStimulus(e, o);
      compareObs($sformatf("rnd%0d op=%b d=%0d", n, rop, rd), e, o);
      if (o.halt != 0 || o.done == 0) begin resetDut(); launch(); end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
